agc_muldiv: RTL and testbench

Iterative ones'-complement multiply/divide unit for the AGC datapath, directly downstream of the control-pulse sequencer. The sequencer's MP and DV steps hand operands over here instead of relying on a single-cycle ALU. It returns the high word for A and the low word for L, with a start/busy/done handshake and a fixed latency.

---
 rtl/agc_defs.sv | 13 +
 rtl/agc_oc_signmag.sv | 17 +
 rtl/agc_muldiv.sv | 173 +++++++++++++++++
 tb/tb_agc_muldiv.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/agc_defs.sv
// Shared AGC word definitions for the iterative multiply/divide unit:
// word geometry, op and state encodings, ones'-complement negative zero.
package agc_defs;
    localparam int WORD_W = 15;
    localparam int MAG_W  = 14;

    localparam logic MD_MP = 1'b0;
    localparam logic MD_DV = 1'b1;

    localparam logic [WORD_W-1:0] NEG_ZERO = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_e;
endpackage

// File: rtl/agc_oc_signmag.sv
// Ones'-complement word <-> sign/magnitude conversion, purely combinational.
// One instance both splits an incoming word and rebuilds an outgoing one.
module agc_oc_signmag
    import agc_defs::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic              sign_o,
    output logic [MAG_W-1:0]  mag_o,
    input  logic              sign_i,
    input  logic [MAG_W-1:0]  mag_i,
    output logic [WORD_W-1:0] word_o
);
    assign sign_o = word_i[WORD_W-1];
    assign mag_o  = sign_o ? ~word_i[MAG_W-1:0] : word_i[MAG_W-1:0];
    // Complementing against all-ones gives -0 for a zero magnitude.
    assign word_o = sign_i ? (NEG_ZERO ^ {1'b0, mag_i}) : {1'b0, mag_i};
endmodule

// File: rtl/agc_muldiv.sv
// Iterative ones'-complement MP/DV unit with fixed 16-cycle latency.
// Define MULDIV_DV_EN to build the restoring divider; otherwise DV always overflows.
module agc_muldiv #(
    parameter int WORD_W = 15,
    parameter int ITER   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] l,
    input  logic [WORD_W-1:0] y,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              dv_ovf
);
    import agc_defs::*;

    localparam int MW = WORD_W - 1;
    localparam int CW = $clog2(ITER);

    md_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic                   op_q, hs_q, ls_q, ovf_q, dv_ovf_q;
    logic [WORD_W-1:0]      x_q, l_q, hi_q, lo_q;
    logic [MW-1:0]          mx_q, my_q;
    logic [2*MW:0]          acc_q, acc_d;
    logic [MW+1:0]          sum;
    logic                   hs_cap, ls_cap, ovf_cap;
    logic [1:0][WORD_W-1:0] sm_word, sm_res;
    logic [1:0]             sm_sign, res_sign;
    logic [1:0][MW-1:0]     sm_mag, res_mag;

    // Lane 0 splits x / forms hi, lane 1 splits y / forms lo.
    assign sm_word  = {y, x};
    assign res_sign = {ls_q, hs_q};

    for (genvar g = 0; g < 2; g++) begin : g_sm
        agc_oc_signmag u_sm (
            .word_i (sm_word[g]),
            .sign_o (sm_sign[g]),
            .mag_o  (sm_mag[g]),
            .sign_i (res_sign[g]),
            .mag_i  (res_mag[g]),
            .word_o (sm_res[g])
        );
    end

`ifdef MULDIV_DV_EN
    logic [MW-1:0] ml, rem_q, quo_q;
    logic          ds, ge;
    logic [MW:0]   t;

    assign ml = l[MW] ? ~l[MW-1:0] : l[MW-1:0];
    assign ds = (sm_mag[0] == '0) ? l[MW] : sm_sign[0];
    assign t  = {rem_q, quo_q[MW-1]};
    assign ge = (t >= {1'b0, my_q});
`endif

    always_comb begin
        hs_cap  = sm_sign[0] ^ sm_sign[1];
        ls_cap  = hs_cap;
        ovf_cap = (op == MD_DV);
`ifdef MULDIV_DV_EN
        if (op == MD_DV) begin
            hs_cap  = ds ^ sm_sign[1];
            ls_cap  = ds;
            ovf_cap = (sm_mag[0] >= sm_mag[1]);
        end
`endif
    end

    always_comb begin
        res_mag[0] = acc_q[2*MW-1:MW];
        res_mag[1] = acc_q[MW-1:0];
`ifdef MULDIV_DV_EN
        if (op_q == MD_DV) begin
            res_mag[0] = quo_q;
            res_mag[1] = rem_q;
        end
`endif
    end

    // Shift-add, multiplier consumed LSB-first from the low half of acc.
    assign sum   = {1'b0, acc_q[2*MW:MW]} + (acc_q[0] ? {2'b00, mx_q} : '0);
    assign acc_d = {sum, acc_q[MW-1:1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= 1'b0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
            ovf_q    <= 1'b0;
            x_q      <= '0;
            l_q      <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_ovf_q <= 1'b0;
`ifdef MULDIV_DV_EN
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cnt_q <= CW'(ITER - 1);
                    op_q  <= op;
                    hs_q  <= hs_cap;
                    ls_q  <= ls_cap;
                    ovf_q <= ovf_cap;
                    x_q   <= x;
                    l_q   <= l;
                    mx_q  <= sm_mag[0];
                    my_q  <= sm_mag[1];
                    acc_q <= {{(MW+1){1'b0}}, sm_mag[1]};
`ifdef MULDIV_DV_EN
                    rem_q <= sm_mag[0];
                    quo_q <= ml;
`endif
                end
                RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    acc_q <= acc_d;
`ifdef MULDIV_DV_EN
                    rem_q <= ge ? (t[MW-1:0] - my_q) : t[MW-1:0];
                    quo_q <= {quo_q[MW-2:0], ge};
`endif
                end
                FIX: begin
                    // Overflowed divides hand the dividend back untouched.
                    if (op_q == MD_MP || !ovf_q) begin
                        hi_q <= sm_res[0];
                        lo_q <= sm_res[1];
                    end else begin
                        hi_q <= x_q;
                        lo_q <= l_q;
                    end
                    dv_ovf_q <= (op_q == MD_DV) && ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign dv_ovf = dv_ovf_q;
endmodule

// File: tb/tb_agc_muldiv.sv
// Self-checking bench for agc_muldiv: directed vectors, randomized ops against
// an arithmetic reference model, handshake, back-to-back and mid-op reset.
module tb_agc_muldiv;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [14:0] x, l, y;
    logic        busy, done, dv_ovf;
    logic [14:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    agc_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .x(x), .l(l), .y(y),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .dv_ovf(dv_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mag(input logic [14:0] w);
        return w[14] ? (32'h7FFF - int'(w)) : int'(w);
    endfunction

    function automatic logic [14:0] oc(input logic s, input int m);
        return s ? 15'(32'h7FFF - m) : 15'(m);
    endfunction

    task automatic model(input logic o, input logic [14:0] a, input logic [14:0] b,
                         input logic [14:0] c, output logic [14:0] eh,
                         output logic [14:0] el, output logic eo);
        int mx, ml, my, p, d;
        logic ds;
        mx = mag(a); ml = mag(b); my = mag(c);
        if (o == 1'b0) begin
            p  = mx * my;
            eh = oc(a[14] ^ c[14], p / 16384);
            el = oc(a[14] ^ c[14], p % 16384);
            eo = 1'b0;
        end else begin
            eh = a; el = b; eo = 1'b1;
`ifdef MULDIV_DV_EN
            if (mx < my) begin
                d  = mx * 16384 + ml;
                ds = (mx == 0) ? b[14] : a[14];
                eh = oc(ds ^ c[14], d / my);
                el = oc(ds, d % my);
                eo = 1'b0;
            end
`endif
        end
    endtask

    // Issues one op from IDLE, scrambles inputs after accept, reports latency,
    // results at the done cycle and whether busy/done behaved around it.
    task automatic run_op(input logic o, input logic [14:0] a, input logic [14:0] b,
                          input logic [14:0] c, output int lat, output logic [14:0] gh,
                          output logic [14:0] gl, output logic go, output logic busy_ok,
                          output logic post_ok);
        start = 1'b1; op = o; x = a; l = b; y = c;
        tick();
        start = 1'b0; op = 1'($urandom); x = 15'($urandom); l = 15'($urandom); y = 15'($urandom);
        lat = -1; busy_ok = 1'b1; post_ok = 1'b0; gh = '0; gl = '0; go = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = cyc; gh = hi; gl = lo; go = dv_ovf;
                break;
            end
            tick();
        end
        if (lat > 0) begin
            tick();
            post_ok = !done && !busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; x = '0; l = '0; y = '0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (hi !== 15'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 15'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (dv_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", dv_ovf); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic        vo [7];
        logic [14:0] va [7], vb [7], vc [7], eh [7], el [7];
        logic        eo [7];
        int lat; logic [14:0] gh, gl; logic go, bok, pok;
        vo[0] = 0; va[0] = 15'd3;    vb[0] = 0;       vc[0] = 15'd5;    eh[0] = 15'h0;    el[0] = 15'h000F; eo[0] = 0;
        vo[1] = 0; va[1] = 15'h7FFC; vb[1] = 0;       vc[1] = 15'd5;    eh[1] = 15'h7FFF; el[1] = 15'h7FF0; eo[1] = 0;
        vo[2] = 0; va[2] = 15'h3FFF; vb[2] = 0;       vc[2] = 15'h3FFF; eh[2] = 15'h3FFE; el[2] = 15'h0001; eo[2] = 0;
`ifdef MULDIV_DV_EN
        vo[3] = 1; va[3] = 15'd0;    vb[3] = 15'd100; vc[3] = 15'd7;    eh[3] = 15'd14;   el[3] = 15'd2;    eo[3] = 0;
        vo[6] = 1; va[6] = 15'd0;    vb[6] = 15'h7F9B; vc[6] = 15'd7;   eh[6] = 15'h7FF1; el[6] = 15'h7FFD; eo[6] = 0;
`else
        vo[3] = 1; va[3] = 15'd0;    vb[3] = 15'd100; vc[3] = 15'd7;    eh[3] = 15'd0;    el[3] = 15'd100;  eo[3] = 1;
        vo[6] = 1; va[6] = 15'd0;    vb[6] = 15'h7F9B; vc[6] = 15'd7;   eh[6] = 15'd0;    el[6] = 15'h7F9B; eo[6] = 1;
`endif
        vo[4] = 1; va[4] = 15'd7;    vb[4] = 15'd1;   vc[4] = 15'd7;    eh[4] = 15'd7;    el[4] = 15'd1;    eo[4] = 1;
        vo[5] = 1; va[5] = 15'd0;    vb[5] = 15'd5;   vc[5] = 15'h7FFF; eh[5] = 15'd0;    el[5] = 15'd5;    eo[5] = 1;
        for (int i = 0; i < 7; i++) begin
            run_op(vo[i], va[i], vb[i], vc[i], lat, gh, gl, go, bok, pok);
            total++; if (lat != 16) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=16", i, lat); end
            total++; if (gh !== eh[i]) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, gh, eh[i]); end
            total++; if (gl !== el[i]) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, gl, el[i]); end
            total++; if (go !== eo[i]) begin bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, go, eo[i]); end
            total++; if (!bok || !pok) begin bad++; $display("FAIL dir%0d_busy_done busy_ok=%b post_ok=%b exp=1/1", i, bok, pok); end
        end
    endtask

    task automatic test_random();
        int lat, mx, my; logic [14:0] a, b, c, gh, gl, eh, el; logic o, go, eo, bok, pok;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom); b = 15'($urandom); c = 15'($urandom); a = 15'($urandom);
            my = mag(c);
            if (o && my > 0 && $urandom_range(0, 3) != 0) begin
                mx = int'($urandom_range(0, my - 1));
                a  = oc(1'($urandom), mx);
            end
            model(o, a, b, c, eh, el, eo);
            run_op(o, a, b, c, lat, gh, gl, go, bok, pok);
            total++;
            if (lat != 16 || gh !== eh || gl !== el || go !== eo || !bok || !pok) begin
                bad++;
                $display("FAIL rand%0d op=%b x=%h l=%h y=%h got lat=%0d hi=%h lo=%h ovf=%b exp lat=16 hi=%h lo=%h ovf=%b",
                         i, o, a, b, c, lat, gh, gl, go, eh, el, eo);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int n, lat; logic [14:0] gh, gl;
        start = 1'b1; op = 1'b0; x = 15'd3; l = '0; y = 15'd5;
        tick();
        start = 1'b0; n = 0; lat = -1; gh = '0; gl = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                n++;
                if (lat < 0) begin lat = cyc; gh = hi; gl = lo; end
            end
            if (cyc == 5) begin start = 1'b1; op = 1'b0; x = 15'd100; y = 15'd100; end
            else start = 1'b0;
            tick();
        end
        total++; if (n != 1) begin bad++; $display("FAIL busy_start_done_count got=%0d exp=1", n); end
        total++; if (lat != 16) begin bad++; $display("FAIL busy_start_latency got=%0d exp=16", lat); end
        total++; if (gh !== 15'h0 || gl !== 15'h000F) begin bad++; $display("FAIL busy_start_result got=%h/%h exp=0000/000f", gh, gl); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [14:0] eh, el; logic eo;
        start = 1'b1; op = 1'b0; x = 15'h1234; l = '0; y = 15'h0567;
        tick();
        start = 1'b0; lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin lat = cyc; break; end
            tick();
        end
        total++; if (lat != 16) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=16", lat); end
        // start during the DONE cycle must be dropped
        start = 1'b1; op = 1'b1; x = 15'd1; l = 15'd2; y = 15'd3;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start_ignored busy=%b exp=0", busy); end
        start = 1'b1; op = 1'b0; x = 15'h3FFF; l = '0; y = 15'h1234;
        model(1'b0, 15'h3FFF, 15'h0, 15'h1234, eh, el, eo);
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_cycle17 busy=%b exp=1", busy); end
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin lat = cyc; break; end
            tick();
        end
        total++;
        if (lat != 16 || hi !== eh || lo !== el || dv_ovf !== eo) begin
            bad++;
            $display("FAIL b2b_second got lat=%0d hi=%h lo=%h ovf=%b exp lat=16 hi=%h lo=%h ovf=%b", lat, hi, lo, dv_ovf, eh, el, eo);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n; int lat; logic [14:0] gh, gl; logic go, bok, pok;
        start = 1'b1; op = 1'b0; x = 15'h2222; l = '0; y = 15'h0333;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) tick();
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        total++; if (hi !== 15'h0 || lo !== 15'h0 || dv_ovf !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs got=%h/%h/%b exp=0/0/0", hi, lo, dv_ovf);
        end
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done || busy) n++;
            tick();
        end
        total++; if (n != 0) begin bad++; $display("FAIL midreset_no_done got=%0d active cycles exp=0", n); end
        run_op(1'b0, 15'd3, 15'd0, 15'd5, lat, gh, gl, go, bok, pok);
        total++; if (lat != 16 || gh !== 15'h0 || gl !== 15'h000F || go !== 1'b0) begin
            bad++; $display("FAIL restart got lat=%0d hi=%h lo=%h ovf=%b exp lat=16 hi=0000 lo=000f ovf=0", lat, gh, gl, go);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
